// File: rtl/wavetable_mixer.sv
// Wavetable mixer: scans all voices once per sample tick, reads one wavetable ROM
// address per cycle, and sums the gated voices into one signed output sample.
module wavetable_mixer #(
  parameter int unsigned NUM_VOICES  = 24,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT       = 0
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              sample_tick_in,
  input  logic [NUM_VOICES-1:0]             gate_in,
  input  logic [NUM_VOICES-1:0][31:0]       phase_value_in,
  output logic [ADDR_WIDTH-1:0]             rom_addr_out,
  input  logic signed [DATA_WIDTH-1:0]      rom_data_in,
  output logic signed [OUT_WIDTH-1:0]       sample_out,
  output logic                              sample_valid_out,
  output logic                              busy_out,
  output logic                              overrun_out
);

  // Wide enough that summing every voice at full scale cannot overflow.
  localparam int unsigned ACC_W   = DATA_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned DRAIN_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e                               state_q;
  logic [NUM_VOICES-1:0]                snap_gate_q;
  // Only the address bits of each phase word are ever used, so only those are held.
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] snap_addr_q;
  logic [VOICE_W-1:0]                   voice_q;
  logic [VOICE_W-1:0]                   voice_nxt;
  logic [DRAIN_W-1:0]                   drain_q;
  // Tag pipeline mirrors the ROM latency: bit ROM_LATENCY-1 lines up with rom_data_in.
  logic [ROM_LATENCY-1:0]               pipe_vld_q;
  logic [ROM_LATENCY-1:0]               pipe_gate_q;
  logic signed [ACC_W-1:0]              acc_q;
  logic signed [ACC_W-1:0]              acc_sum;
  logic signed [ACC_W-1:0]              rom_ext;
  logic signed [ACC_W-1:0]              shifted;
  logic signed [OUT_WIDTH-1:0]          sat_sum;
  logic                                 ret_hit;
  logic                                 unused_phase;

  // Low phase bits are fractional position and deliberately ignored.
  assign unused_phase = ^phase_value_in;

  // A tick that arrives while a scan is in flight is dropped and flagged.
  assign overrun_out = sample_tick_in & busy_out;

  // Accumulator next value: add the returning ROM word only for gated voices.
  always_comb begin
    voice_nxt = voice_q + VOICE_W'(1);
    ret_hit   = pipe_vld_q[ROM_LATENCY-1] & pipe_gate_q[ROM_LATENCY-1];
    rom_ext   = {{(ACC_W - DATA_WIDTH){rom_data_in[DATA_WIDTH-1]}}, rom_data_in};
    acc_sum   = ret_hit ? (acc_q + rom_ext) : acc_q;
    shifted   = acc_sum >>> SHIFT;
  end

  // Fit the shifted sum into the output width, saturating if it is narrower.
  if (OUT_WIDTH > ACC_W) begin : g_extend
    always_comb begin
      sat_sum = {{(OUT_WIDTH - ACC_W){shifted[ACC_W-1]}}, shifted};
    end
  end else if (OUT_WIDTH == ACC_W) begin : g_same
    always_comb begin
      sat_sum = shifted;
    end
  end else begin : g_saturate
    logic [ACC_W-OUT_WIDTH:0] top_bits;
    always_comb begin
      top_bits = shifted[ACC_W-1:OUT_WIDTH-1];
      if ((&top_bits) || !(|top_bits)) begin
        sat_sum = shifted[OUT_WIDTH-1:0];
      end else if (shifted[ACC_W-1]) begin
        sat_sum = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      end else begin
        sat_sum = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      end
    end
  end

  // Tag pipeline: one entry per issued address, aligned with ROM data return.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_vld_q  <= '0;
      pipe_gate_q <= '0;
    end else begin
      pipe_vld_q[0]  <= (state_q == StScan);
      pipe_gate_q[0] <= snap_gate_q[voice_q];
      for (int i = 1; i < int'(ROM_LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_gate_q[i] <= pipe_gate_q[i-1];
      end
    end
  end

  // Scan FSM with snapshot, accumulator and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= StIdle;
      snap_gate_q      <= '0;
      snap_addr_q      <= '0;
      voice_q          <= '0;
      drain_q          <= '0;
      acc_q            <= '0;
      rom_addr_out     <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      busy_out         <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sample_tick_in) begin
            snap_gate_q <= gate_in;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
              snap_addr_q[v] <= phase_value_in[v][31 -: ADDR_WIDTH];
            end
            // Voice 0 address goes straight out so it is on the bus in cycle 1.
            rom_addr_out <= phase_value_in[0][31 -: ADDR_WIDTH];
            voice_q      <= '0;
            acc_q        <= '0;
            busy_out     <= 1'b1;
            state_q      <= StScan;
          end
        end
        StScan: begin
          acc_q <= acc_sum;
          if (voice_q == LAST_VOICE) begin
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            voice_q      <= voice_nxt;
            rom_addr_out <= snap_addr_q[voice_nxt];
          end
        end
        StDrain: begin
          acc_q <= acc_sum;
          // The last voice returns on the final drain cycle; publish including it.
          if (drain_q == LAST_DRAIN) begin
            sample_out       <= sat_sum;
            sample_valid_out <= 1'b1;
            state_q          <= StDone;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        StDone: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_mixer.sv
// Directed bench for wavetable_mixer with a latency-2 sine ROM model.
module tb_wavetable_mixer;

  localparam int N = 24;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    sample_tick_in;
  logic [N-1:0]            gate_in;
  logic [N-1:0][31:0]      phase_value_in;
  logic [7:0]              rom_addr_out;
  logic signed [7:0]       rom_data_in;
  logic signed [15:0]      sample_out;
  logic                    sample_valid_out;
  logic                    busy_out;
  logic                    overrun_out;

  logic signed [7:0]       rom [256];
  logic signed [7:0]       rom_d1;
  logic signed [7:0]       rom_d2;
  logic [N-1:0][31:0]      ph;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  // Two-stage ROM model: data for an address appears two cycles later.
  always @(posedge clk_in) begin
    rom_d1 <= rom[rom_addr_out];
    rom_d2 <= rom_d1;
  end
  assign rom_data_in = rom_d2;

  wavetable_mixer dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_tick_in   (sample_tick_in),
    .gate_in          (gate_in),
    .phase_value_in   (phase_value_in),
    .rom_addr_out     (rom_addr_out),
    .rom_data_in      (rom_data_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One full scan from tick (cycle 0) through cycle 28.
  task automatic run_scan(input string tag, input logic [N-1:0] g,
                          input logic [N-1:0][31:0] p, input longint exp,
                          input bit mid_change);
    int valids = 0;
    @(negedge clk_in);
    gate_in = g;
    phase_value_in = p;
    sample_tick_in = 1'b1;
    #1;
    check({tag, "/ovr_c0"}, overrun_out, 0);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk_in);
      sample_tick_in = 1'b0;
      if (mid_change && k == 5) begin
        phase_value_in[0] = 32'hC000_0000;
        gate_in = ~g;
      end
      if (k <= 27 && sample_valid_out) valids++;
      if (k == 1) begin
        check({tag, "/busy_c1"}, busy_out, 1);
        check({tag, "/addr_c1"}, rom_addr_out, longint'(p[0][31:24]));
      end
      if (k == 26) check({tag, "/valid_c26"}, sample_valid_out, 0);
      if (k == 27) begin
        check({tag, "/valid_c27"}, sample_valid_out, 1);
        check({tag, "/sample"}, sample_out, exp);
      end
      if (k == 28) begin
        check({tag, "/valid_c28"}, sample_valid_out, 0);
        check({tag, "/busy_c28"}, busy_out, 0);
        check({tag, "/held"}, sample_out, exp);
      end
    end
    check({tag, "/valid_count"}, valids, 1);
  endtask

  initial begin
    real r;
    int  valids;
    for (int i = 0; i < 256; i++) begin
      r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
      rom[i] = (r >= 0.0) ? 8'($rtoi(r + 0.5)) : -8'($rtoi(-r + 0.5));
    end

    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    gate_in = '0;
    phase_value_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst/sample", sample_out, 0);
    check("rst/valid", sample_valid_out, 0);
    check("rst/busy", busy_out, 0);
    check("rst/addr", rom_addr_out, 0);
    check("rst/ovr", overrun_out, 0);
    rst_in = 1'b0;

    // Single voice at quarter phase: peak of the sine.
    ph = '0;
    ph[0] = 32'h4000_0000;
    run_scan("one_voice", 24'h000001, ph, 127, 1'b0);

    // All voices at the positive and negative peaks.
    for (int i = 0; i < N; i++) ph[i] = 32'h4000_0000;
    run_scan("all_pos", 24'hFFFFFF, ph, 3048, 1'b0);
    for (int i = 0; i < N; i++) ph[i] = 32'hC000_0000;
    run_scan("all_neg", 24'hFFFFFF, ph, -3048, 1'b0);

    // No gated voices: still a valid pulse, value zero.
    for (int i = 0; i < N; i++) ph[i] = 32'h1234_5678 * (i + 1);
    run_scan("no_gate", 24'h000000, ph, 0, 1'b0);

    // Two voices: sin(pi/4) rounds to 90, plus the peak.
    ph = '0;
    ph[0] = 32'h2000_0000;
    ph[1] = 32'h4000_0000;
    run_scan("two_voice", 24'h000003, ph, 217, 1'b0);

    // Gate mask selects only voice 1 (negative peak).
    ph[0] = 32'h4000_0000;
    ph[1] = 32'hC000_0000;
    run_scan("mask", 24'h000002, ph, -127, 1'b0);

    // Overrun: ticks at cycles 10 and 27 dropped, one valid at 27.
    ph = '0;
    ph[0] = 32'h4000_0000;
    valids = 0;
    @(negedge clk_in);
    gate_in = 24'h000001;
    phase_value_in = ph;
    sample_tick_in = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk_in);
      sample_tick_in = (k == 10 || k == 27);
      #1;
      if (k < 27 && sample_valid_out) valids++;
      if (k == 10) check("ovr/pulse_c10", overrun_out, 1);
      if (k == 11) check("ovr/clear_c11", overrun_out, 0);
      if (k == 27) begin
        check("ovr/pulse_c27", overrun_out, 1);
        check("ovr/valid_c27", sample_valid_out, 1);
        check("ovr/sample", sample_out, 127);
      end
    end
    check("ovr/early_valids", valids, 0);
    // Tick at cycle 28 must be accepted as a fresh scan.
    ph[0] = 32'hC000_0000;
    run_scan("after_ovr", 24'h000001, ph, -127, 1'b0);

    // Mid-scan input change must not disturb the snapshot.
    ph[0] = 32'h4000_0000;
    run_scan("snapshot", 24'h000001, ph, 127, 1'b1);

    // Reset at cycle 12 aborts the scan.
    @(negedge clk_in);
    gate_in = 24'h000001;
    phase_value_in = ph;
    sample_tick_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      sample_tick_in = 1'b0;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    check("abort/busy", busy_out, 0);
    check("abort/sample", sample_out, 0);
    check("abort/valid", sample_valid_out, 0);
    check("abort/addr", rom_addr_out, 0);
    rst_in = 1'b0;
    valids = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (sample_valid_out) valids++;
    end
    check("abort/no_valid", valids, 0);

    ph[0] = 32'h2000_0000;
    ph[1] = 32'h4000_0000;
    run_scan("post_abort", 24'h000003, ph, 217, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
